// File: rtl/ks_pkg.sv
// Shared types and character constants for the arcfour key search controller.
package ks_pkg;
   typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ABORT, NEXT, FOUND, FAIL} ks_state_t;

   localparam logic [7:0] CHAR_LO = 8'h61;
   localparam logic [7:0] CHAR_HI = 8'h7A;
   localparam logic [7:0] CHAR_SP = 8'h20;
endpackage

// File: rtl/printable_check.sv
// Combinational test: is a decrypted byte a lowercase letter or a space.
module printable_check
   import ks_pkg::*;
(
   input  logic [7:0] byte_i,
   output logic       valid_o
);
   assign valid_o = ((byte_i >= CHAR_LO) && (byte_i <= CHAR_HI)) || (byte_i == CHAR_SP);
endmodule

// File: rtl/key_search_ctrl.sv
// Brute-force key scheduler for arcfour: launches keys, snoops A RAM writes, stops on a clean message.
// Build option EARLY_ABORT_EN: abort arcfour on the first invalid byte instead of waiting for finish.
module key_search_ctrl
   import ks_pkg::*;
#(
   parameter int              KEY_W   = 24,
   parameter logic [KEY_W-1:0] KEY_MIN = '0,
   parameter logic [KEY_W-1:0] KEY_MAX = KEY_W'(24'h3FFFFF),
   parameter int              MSG_LEN = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   output logic [KEY_W-1:0] key,
   output logic             rc_start,
   output logic             rc_reset,
   input  logic             rc_finished,
   input  logic             a_wren,
   input  logic [7:0]       a_addr,
   input  logic [7:0]       a_data,
   output logic             busy,
   output logic             found,
   output logic             exhausted
);
   localparam logic [8:0] MSG_LEN_W = 9'(MSG_LEN);

   ks_state_t        state_q, state_d;
   logic [KEY_W-1:0] key_q, key_d;
   logic             bad_q, bad_d;
   logic             rc_start_q, busy_q, found_q, exhausted_q;
   logic             byte_valid, byte_bad;

   printable_check u_check (
      .byte_i  (a_data),
      .valid_o (byte_valid)
   );

   // Writes beyond the message are scratch data and must not condemn a key.
   assign byte_bad = a_wren && ({1'b0, a_addr} < MSG_LEN_W) && !byte_valid;

   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      bad_d   = bad_q;
      unique case (state_q)
         IDLE, FOUND, FAIL: begin
            if (start) begin
               key_d   = KEY_MIN;
               state_d = LAUNCH;
            end
         end
         LAUNCH: begin
            bad_d   = 1'b0;
            state_d = RUN;
         end
         RUN: begin
            if (byte_bad) bad_d = 1'b1;
            if (rc_finished) begin
               state_d = (bad_q || byte_bad) ? NEXT : FOUND;
            end
`ifdef EARLY_ABORT_EN
            else if (byte_bad) begin
               state_d = ABORT;
            end
`endif
         end
         ABORT: state_d = NEXT;
         NEXT: begin
            if (key_q == KEY_MAX) begin
               state_d = FAIL;
            end else begin
               key_d   = key_q + KEY_W'(1);
               state_d = LAUNCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every one leaves a flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         key_q       <= KEY_MIN;
         bad_q       <= 1'b0;
         rc_start_q  <= 1'b0;
         busy_q      <= 1'b0;
         found_q     <= 1'b0;
         exhausted_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         bad_q       <= bad_d;
         rc_start_q  <= (state_d == LAUNCH);
         busy_q      <= (state_d == LAUNCH) || (state_d == RUN) ||
                        (state_d == ABORT)  || (state_d == NEXT);
         found_q     <= (state_d == FOUND);
         exhausted_q <= (state_d == FAIL);
      end
   end

`ifdef EARLY_ABORT_EN
   logic rc_reset_q;
   always_ff @(posedge clk) begin
      if (reset) rc_reset_q <= 1'b0;
      else       rc_reset_q <= (state_d == ABORT);
   end
   assign rc_reset = rc_reset_q;
`else
   assign rc_reset = 1'b0;
`endif

   assign key       = key_q;
   assign rc_start  = rc_start_q;
   assign busy      = busy_q;
   assign found     = found_q;
   assign exhausted = exhausted_q;
endmodule

// File: tb/tb_key_search_ctrl.sv
// Scoreboard bench for key_search_ctrl with a behavioural arcfour emulator driving the snooped bus.
module tb_key_search_ctrl;
   localparam int KEY_W   = 24;
   localparam int KMAX    = 3;
   localparam int MSG_LEN = 32;

   logic             clk = 1'b0;
   logic             reset, start, rc_finished, a_wren;
   logic [7:0]       a_addr, a_data;
   logic [KEY_W-1:0] key;
   logic             rc_start, rc_reset, busy, found, exhausted;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int plan [0:KMAX];    // per key: 0 clean, 1 bad byte mid-message, 2 bad byte with finish
   int force_badpos = -1;
   int exp_q [$];
   int n_start, n_reset;
   int start_cyc, last_fail_cyc, fail_lat;
   bit first_launch;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   key_search_ctrl #(
      .KEY_W   (KEY_W),
      .KEY_MIN (24'd0),
      .KEY_MAX (24'(KMAX)),
      .MSG_LEN (MSG_LEN)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .key         (key),
      .rc_start    (rc_start),
      .rc_reset    (rc_reset),
      .rc_finished (rc_finished),
      .a_wren      (a_wren),
      .a_addr      (a_addr),
      .a_data      (a_data),
      .busy        (busy),
      .found       (found),
      .exhausted   (exhausted)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic bit is_valid(input logic [7:0] b);
      return ((b >= 8'h61) && (b <= 8'h7A)) || (b == 8'h20);
   endfunction

   function automatic logic [7:0] rand_good();
      int r = $urandom_range(0, 26);
      return (r == 26) ? 8'h20 : 8'(8'h61 + r);
   endfunction

   function automatic logic [7:0] rand_bad();
      logic [7:0] tbl [8] = '{8'h41, 8'h60, 8'h7B, 8'h1F, 8'h21, 8'h00, 8'hFF, 8'h5A};
      logic [7:0] b;
      if ($urandom_range(0, 1) == 0) return tbl[$urandom_range(0, 7)];
      do b = 8'($urandom); while (is_valid(b));
      return b;
   endfunction

   function automatic logic [7:0] rand_oor();
      int s = $urandom_range(0, 2);
      return (s == 0) ? 8'd32 : ((s == 1) ? 8'd40 : 8'd255);
   endfunction

   // Arcfour emulator: one message per launched key, aborted by rc_reset or reset.
   task automatic run_key(input int k);
      int kind   = plan[k];
      int badpos = (force_badpos >= 0) ? force_badpos : $urandom_range(0, MSG_LEN - 1);
      int i      = 0;
      bit oor_done = 1'b0;
      while (i <= MSG_LEN) begin
         @(negedge clk);
         a_wren      = 1'b0;
         rc_finished = 1'b0;
         if (reset || rc_reset) return;
         if (!oor_done) begin
            a_wren = 1'b1; a_addr = 8'd40; a_data = 8'h00;
            oor_done = 1'b1;
         end else if (i == MSG_LEN) begin
            rc_finished = 1'b1;
            if (kind == 2) begin
               a_wren = 1'b1;
               a_addr = 8'($urandom_range(0, MSG_LEN - 1));
               a_data = rand_bad();
            end
            if (kind != 0) begin
               last_fail_cyc = cyc;
               fail_lat      = 2;
            end
            i++;
         end else if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 1) begin
               a_wren = 1'b1; a_addr = rand_oor(); a_data = 8'h00;
            end
         end else begin
            a_wren = 1'b1;
            a_addr = 8'(i);
            a_data = (kind == 1 && i == badpos) ? rand_bad() : rand_good();
`ifdef EARLY_ABORT_EN
            if (kind == 1 && i == badpos) begin
               last_fail_cyc = cyc;
               fail_lat      = 3;
            end
`endif
            i++;
         end
      end
   endtask

   initial begin
      a_wren = 1'b0; a_addr = '0; a_data = '0; rc_finished = 1'b0;
      forever begin
         @(negedge clk);
         a_wren      = 1'b0;
         rc_finished = 1'b0;
         if (rc_start === 1'b1 && !reset) run_key(int'(key));
      end
   end

   // Monitor: every rc_start pops the scoreboard and checks key and launch latency.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         if (rc_start) begin
            n_start++;
            check("rc_start_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) check("launch_key", key, exp_q.pop_front());
            if (first_launch) check("start_to_rc_start", cyc - start_cyc, 1);
            else              check("fail_to_rc_start", cyc - last_fail_cyc, fail_lat);
            first_launch = 1'b0;
         end
         if (rc_reset) begin
            n_reset++;
            check("bad_to_rc_reset", cyc - last_fail_cyc, 1);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      start        = 1'b1;
      start_cyc    = cyc;
      first_launch = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic run_search(input string name, input int inject_at);
      int exp_key    = KMAX;
      int exp_starts = 0;
      int exp_resets = 0;
      bit exp_found  = 1'b0;
      bit done       = 1'b0;
      int inj_t      = 0;
      exp_q.delete();
      n_start = 0;
      n_reset = 0;
      for (int k = 0; k <= KMAX; k++) begin
         exp_q.push_back(k);
         exp_starts++;
`ifdef EARLY_ABORT_EN
         if (plan[k] == 1) exp_resets++;
`endif
         if (plan[k] == 0) begin
            exp_found = 1'b1;
            exp_key   = k;
            break;
         end
      end
      pulse_start();
      for (int t = 0; t < 4000 && !done; t++) begin
         @(negedge clk);
         if (!busy && (found || exhausted)) done = 1'b1;
         if (inject_at > 0 && n_start == inject_at) inj_t++;
         start = (inj_t == 3);
      end
      start = 1'b0;
      check({name, "_completed"}, done, 1);
      check({name, "_found"}, found, exp_found);
      check({name, "_exhausted"}, exhausted, !exp_found);
      check({name, "_key"}, key, exp_key);
      check({name, "_busy"}, busy, 0);
      check({name, "_rc_starts"}, n_start, exp_starts);
      check({name, "_rc_resets"}, n_reset, exp_resets);
      check({name, "_scoreboard_empty"}, exp_q.size(), 0);
      $display("search %s: plan=%0d%0d%0d%0d key=%0d found=%0d exhausted=%0d rc_starts=%0d rc_resets=%0d",
               name, plan[0], plan[1], plan[2], plan[3], key, found, exhausted, n_start, n_reset);
   endtask

   initial begin
      bit reached = 1'b0;
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_key", key, 0);
      check("reset_rc_start", rc_start, 0);
      check("reset_rc_reset", rc_reset, 0);
      check("reset_busy", busy, 0);
      check("reset_found", found, 0);
      check("reset_exhausted", exhausted, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      $display("reset: key=%0d busy=%0d found=%0d exhausted=%0d", key, busy, found, exhausted);

      plan = '{0, 0, 0, 0};
      run_search("clean_key0", 0);
      plan = '{1, 1, 1, 0};
      run_search("clean_key3_start_in_run", 2);
      plan = '{1, 2, 1, 1};
      run_search("all_bad", 0);
      force_badpos = 0;
      plan = '{1, 0, 0, 0};
      run_search("bad_at_addr0", 0);
      force_badpos = -1;
      plan = '{2, 0, 0, 0};
      run_search("bad_with_finish", 0);

      for (int n = 0; n < 6; n++) begin
         for (int k = 0; k <= KMAX; k++) begin
            int r = $urandom_range(0, 3);
            plan[k] = (r == 0) ? 0 : ((r == 3) ? 2 : 1);
         end
         run_search($sformatf("random%0d", n), 0);
      end

      // Reset in the middle of a search.
      plan = '{1, 1, 1, 1};
      exp_q.delete();
      for (int k = 0; k <= KMAX; k++) exp_q.push_back(k);
      n_start = 0;
      pulse_start();
      for (int t = 0; t < 500 && !reached; t++) begin
         @(negedge clk);
         if (n_start == 2) reached = 1'b1;
      end
      check("mid_reset_reached_key1", reached, 1);
      repeat (2) @(negedge clk);
      check("mid_reset_busy_before", busy, 1);
      reset = 1'b1;
      @(negedge clk);
      check("mid_reset_busy", busy, 0);
      check("mid_reset_key", key, 0);
      check("mid_reset_rc_start", rc_start, 0);
      check("mid_reset_found", found, 0);
      check("mid_reset_exhausted", exhausted, 0);
      $display("mid-search reset: key=%0d busy=%0d rc_start=%0d", key, busy, rc_start);
      reset = 1'b0;
      exp_q.delete();
      repeat (5) @(negedge clk);
      check("post_reset_idle_busy", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
